reorder_buf: RTL and testbench
==============================

REORDER_BUF -- requirements
Module: reorder_buf

Interface
REQ-001 Parameter DEPTH, default 16: entry count, power of two, at least 4.
REQ-002 Parameter IDX_W, default 4: equals log2(DEPTH); width of every ROB id.
REQ-003 clk  in  1  sole clock; all state updates on its rising edge.
REQ-004 rst  in  1  asynchronous, active-high reset.
REQ-005 rdy  in  1  global enable; state frozen while low.
REQ-006 issue_en / issue_rd / issue_pc / issue_is_store / issue_is_br / issue_pred_taken  in  1/5/32/1/1/1  allocation request and entry fields.
REQ-007 issue_done / issue_val  in  1/32  entry already complete at issue (e.g. LUI), with its result.
REQ-008 free_rob_id  out  IDX_W  id the next accepted issue receives (current tail).
REQ-009 full / empty  out  1/1  count==DEPTH / count==0.
REQ-010 alu_wb_en / alu_wb_id / alu_wb_val / alu_wb_taken / alu_wb_target  in  1/IDX_W/32/1/32  ALU writeback with actual branch outcome.
REQ-011 lsb_wb_en / lsb_wb_id / lsb_wb_val  in  1/IDX_W/32  load/store-unit writeback.
REQ-012 commit_en / commit_id / commit_rd / commit_val / commit_is_store  out  1/IDX_W/5/32/1  registered retire strobe and payload.
REQ-013 flush / flush_pc  out  1/32  registered one-cycle misprediction recovery with redirect PC.

Function
REQ-014 Circular buffer: head, tail (IDX_W bits, wrap DEPTH-1 -> 0), count (IDX_W+1 bits).
REQ-015 Issue is accepted when issue_en && rdy && !full && !flush; it writes entry[tail], sets valid=1, ready=issue_done, tail+1.
REQ-016 Writeback with en=1 to a valid, not-ready entry sets ready=1, stores val; for ALU also stores actual taken and target.
REQ-017 Writeback to an invalid or already-ready entry is ignored.
REQ-018 ALU and LSB writeback to the same id in one cycle: ALU value wins.
REQ-019 Writeback and commit at the same cycle for the head entry: writeback is visible for commit no earlier than the next cycle.
REQ-020 Commit when rdy && entry[head] valid && ready: commit_en=1 next cycle with that entry's fields, entry invalidated, head+1; at most one commit per cycle.
REQ-021 Issue and commit in the same cycle: count unchanged; when full, issue is refused that cycle even though commit frees a slot.
REQ-022 A committing branch mispredicts when actual taken != pred_taken; flush_pc = taken ? target : pc+4 (32-bit wrap).
REQ-023 On mispredicting commit: commit_en=1 and flush=1 next cycle; all entries invalidated, head=tail=0, count=0; a same-cycle issue is discarded.
REQ-024 While flush=1, issue and writebacks are ignored.
REQ-025 commit_en and flush are one-cycle pulses; payload outputs hold last value otherwise.
REQ-026 rdy low: no issue, writeback, or commit takes effect; commit_en=0 and flush=0 next cycle.

Reset
REQ-027 rst asserted at any time, mid-operation included: head=tail=0, count=0, all valid=0, commit_en=0, flush=0, flush_pc=0, commit payload 0, full=0, empty=1, free_rob_id=0.

Verification
REQ-028 Reset, issue 3 entries, then ALU wb ids 2,0,1 -> commits in order 0,1,2 on consecutive cycles; empty=1 afterwards.
REQ-029 DEPTH=16: issue 16 -> full=1, 17th issue refused; commit one while issuing -> tail wraps to 0, free_rob_id=0.
REQ-030 Branch pc=0x100, pred_taken=0, wb taken=1 target=0x200 -> flush=1, flush_pc=0x200, count=0 next cycle; entries behind it never commit.
REQ-031 Branch pc=0x100, pred_taken=1, wb taken=0 -> flush_pc=0x104; correctly predicted branch -> commit_en=1, flush=0.
REQ-032 Same-cycle ALU wb val=5 and LSB wb val=9 to id 3 -> committed commit_val=5; wb to freed id ignored.
REQ-033 rdy=0 for 3 cycles with ready head -> no commit; rst pulse mid-stream -> all outputs at reset values immediately.

Source files
------------

// File: rtl/reorder_buf_if.sv
// Issue, writeback, commit and flush signals of the reorder buffer.
// The core side drives the master modport; the buffer itself uses slave.
interface reorder_buf_if #(
  parameter int IDX_W = 4
);
  logic             rdy;

  logic             issue_en;
  logic [4:0]       issue_rd;
  logic [31:0]      issue_pc;
  logic             issue_is_store;
  logic             issue_is_br;
  logic             issue_pred_taken;
  logic             issue_done;
  logic [31:0]      issue_val;

  logic [IDX_W-1:0] free_rob_id;
  logic             full;
  logic             empty;

  logic             alu_wb_en;
  logic [IDX_W-1:0] alu_wb_id;
  logic [31:0]      alu_wb_val;
  logic             alu_wb_taken;
  logic [31:0]      alu_wb_target;

  logic             lsb_wb_en;
  logic [IDX_W-1:0] lsb_wb_id;
  logic [31:0]      lsb_wb_val;

  logic             commit_en;
  logic [IDX_W-1:0] commit_id;
  logic [4:0]       commit_rd;
  logic [31:0]      commit_val;
  logic             commit_is_store;
  logic             flush;
  logic [31:0]      flush_pc;

  modport master (
    output rdy, issue_en, issue_rd, issue_pc, issue_is_store, issue_is_br,
           issue_pred_taken, issue_done, issue_val,
           alu_wb_en, alu_wb_id, alu_wb_val, alu_wb_taken, alu_wb_target,
           lsb_wb_en, lsb_wb_id, lsb_wb_val,
    input  free_rob_id, full, empty,
           commit_en, commit_id, commit_rd, commit_val, commit_is_store,
           flush, flush_pc
  );

  modport slave (
    input  rdy, issue_en, issue_rd, issue_pc, issue_is_store, issue_is_br,
           issue_pred_taken, issue_done, issue_val,
           alu_wb_en, alu_wb_id, alu_wb_val, alu_wb_taken, alu_wb_target,
           lsb_wb_en, lsb_wb_id, lsb_wb_val,
    output free_rob_id, full, empty,
           commit_en, commit_id, commit_rd, commit_val, commit_is_store,
           flush, flush_pc
  );
endinterface

// File: rtl/reorder_buf.sv
// In-order retirement buffer: circular entry store with out-of-order
// writeback, one commit per cycle and branch-misprediction flush.
module reorder_buf #(
  parameter int DEPTH = 16,
  parameter int IDX_W = 4
) (
  input  logic          clk,
  input  logic          rst,
  reorder_buf_if.slave  bus
);
  typedef logic [IDX_W-1:0] idx_t;
  typedef logic [IDX_W:0]   cnt_t;

  localparam idx_t IDX_ONE  = idx_t'(1);
  localparam cnt_t CNT_FULL = cnt_t'(DEPTH);

  // Control state
  idx_t             head_q, head_d, tail_q, tail_d;
  cnt_t             count_q, count_d;
  logic [DEPTH-1:0] valid_q, valid_d, ready_q, ready_d;

  // Entry payload
  logic [31:0]      pc_q     [DEPTH];
  logic [31:0]      val_q    [DEPTH];
  logic [31:0]      target_q [DEPTH];
  logic [4:0]       rd_q     [DEPTH];
  logic [DEPTH-1:0] store_q, br_q, pred_q, taken_q;

  // Registered outputs
  logic             commit_en_q, commit_en_d;
  idx_t             commit_id_q, commit_id_d;
  logic [4:0]       commit_rd_q, commit_rd_d;
  logic [31:0]      commit_val_q, commit_val_d;
  logic             commit_store_q, commit_store_d;
  logic             flush_q, flush_d;
  logic [31:0]      flush_pc_q, flush_pc_d;

  logic             full, issue_ok, commit_ok, mispredict, alu_ok, lsb_ok;
  logic [31:0]      redirect_pc;

  assign full = (count_q == CNT_FULL);

  always_comb begin
    issue_ok    = bus.rdy && bus.issue_en && !full && !flush_q;
    commit_ok   = bus.rdy && valid_q[head_q] && ready_q[head_q];
    mispredict  = commit_ok && br_q[head_q] && (taken_q[head_q] != pred_q[head_q]);
    redirect_pc = taken_q[head_q] ? target_q[head_q] : pc_q[head_q] + 32'd4;
    alu_ok      = bus.rdy && !flush_q && bus.alu_wb_en
                  && valid_q[bus.alu_wb_id] && !ready_q[bus.alu_wb_id];
    // The ALU owns an id it writes this cycle; a colliding LSB write is dropped.
    lsb_ok      = bus.rdy && !flush_q && bus.lsb_wb_en
                  && valid_q[bus.lsb_wb_id] && !ready_q[bus.lsb_wb_id]
                  && !(alu_ok && (bus.alu_wb_id == bus.lsb_wb_id));
  end

  always_comb begin
    // NOTE: every _d gets its hold value first, so no path leaves it unassigned and no latch is inferred.
    head_d         = head_q;
    tail_d         = tail_q;
    valid_d        = valid_q;
    ready_d        = ready_q;
    commit_en_d    = commit_ok;
    commit_id_d    = commit_id_q;
    commit_rd_d    = commit_rd_q;
    commit_val_d   = commit_val_q;
    commit_store_d = commit_store_q;
    flush_d        = mispredict;
    flush_pc_d     = flush_pc_q;
    count_d        = count_q + {{IDX_W{1'b0}}, issue_ok} - {{IDX_W{1'b0}}, commit_ok};

    if (commit_ok) begin
      valid_d[head_q] = 1'b0;
      ready_d[head_q] = 1'b0;
      head_d          = head_q + IDX_ONE;
      commit_id_d     = head_q;
      commit_rd_d     = rd_q[head_q];
      commit_val_d    = val_q[head_q];
      commit_store_d  = store_q[head_q];
    end
    if (issue_ok) begin
      valid_d[tail_q] = 1'b1;
      ready_d[tail_q] = bus.issue_done;
      tail_d          = tail_q + IDX_ONE;
    end
    if (alu_ok) ready_d[bus.alu_wb_id] = 1'b1;
    if (lsb_ok) ready_d[bus.lsb_wb_id] = 1'b1;

    // Recovery discards every younger entry, including one issued this cycle.
    if (mispredict) begin
      flush_pc_d = redirect_pc;
      valid_d    = '0;
      ready_d    = '0;
      head_d     = '0;
      tail_d     = '0;
      count_d    = '0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q         <= '0;
      tail_q         <= '0;
      count_q        <= '0;
      valid_q        <= '0;
      ready_q        <= '0;
      commit_en_q    <= 1'b0;
      commit_id_q    <= '0;
      commit_rd_q    <= '0;
      commit_val_q   <= '0;
      commit_store_q <= 1'b0;
      flush_q        <= 1'b0;
      flush_pc_q     <= '0;
    end else begin
      head_q         <= head_d;
      tail_q         <= tail_d;
      count_q        <= count_d;
      valid_q        <= valid_d;
      ready_q        <= ready_d;
      commit_en_q    <= commit_en_d;
      commit_id_q    <= commit_id_d;
      commit_rd_q    <= commit_rd_d;
      commit_val_q   <= commit_val_d;
      commit_store_q <= commit_store_d;
      flush_q        <= flush_d;
      flush_pc_q     <= flush_pc_d;
    end
  end

  // NOTE: payload storage is not reset; valid_q alone decides whether an entry's contents mean anything.
  always_ff @(posedge clk) begin
    if (issue_ok) begin
      pc_q[tail_q]     <= bus.issue_pc;
      val_q[tail_q]    <= bus.issue_val;
      target_q[tail_q] <= '0;
      rd_q[tail_q]     <= bus.issue_rd;
      store_q[tail_q]  <= bus.issue_is_store;
      br_q[tail_q]     <= bus.issue_is_br;
      pred_q[tail_q]   <= bus.issue_pred_taken;
      taken_q[tail_q]  <= 1'b0;
    end
    if (alu_ok) begin
      val_q[bus.alu_wb_id]    <= bus.alu_wb_val;
      taken_q[bus.alu_wb_id]  <= bus.alu_wb_taken;
      target_q[bus.alu_wb_id] <= bus.alu_wb_target;
    end
    if (lsb_ok) val_q[bus.lsb_wb_id] <= bus.lsb_wb_val;
  end

  assign bus.free_rob_id     = tail_q;
  assign bus.full            = full;
  assign bus.empty           = (count_q == '0);
  assign bus.commit_en       = commit_en_q;
  assign bus.commit_id       = commit_id_q;
  assign bus.commit_rd       = commit_rd_q;
  assign bus.commit_val      = commit_val_q;
  assign bus.commit_is_store = commit_store_q;
  assign bus.flush           = flush_q;
  assign bus.flush_pc        = flush_pc_q;
endmodule

// File: tb/tb_reorder_buf.sv
// Scoreboard bench for reorder_buf: a queue-based reference model predicts
// commits and flushes; a negedge monitor compares what the DUT presents.
module tb_reorder_buf;
  localparam int DEPTH = 16;
  localparam int IDX_W = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  reorder_buf_if #(.IDX_W(IDX_W)) bif ();
  reorder_buf #(.DEPTH(DEPTH), .IDX_W(IDX_W)) dut (.clk(clk), .rst(rst), .bus(bif));

  typedef struct {
    int          id;
    logic [4:0]  rd;
    logic [31:0] pc, val, target;
    bit          st, br, pred, taken, rdy;
  } ent_t;

  typedef struct {
    int          id;
    logic [4:0]  rd;
    logic [31:0] val;
    bit          st, fl;
    logic [31:0] fpc;
  } exp_t;

  ent_t rob[$];      // oldest first
  exp_t exp_q[$];
  int   m_tail;
  bit   m_flush;
  int   errors = 0;
  int   checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a queue of in-flight instructions, updated per clock.
  int   md_sz;
  bit   md_commit, md_issue, md_mis;
  ent_t md_head, md_new;
  exp_t md_exp;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      rob.delete();
      exp_q.delete();
      m_tail  = 0;
      m_flush = 0;
    end else if (!bif.rdy) begin
      m_flush = 0;
    end else begin
      md_sz     = rob.size();
      md_commit = (md_sz > 0) && rob[0].rdy;
      if (md_commit) md_head = rob[0];
      md_issue  = bif.issue_en && (md_sz < DEPTH) && !m_flush;
      if (!m_flush) begin
        foreach (rob[i]) begin
          if (bif.alu_wb_en && rob[i].id == int'(bif.alu_wb_id) && !rob[i].rdy) begin
            rob[i].rdy    = 1;
            rob[i].val    = bif.alu_wb_val;
            rob[i].taken  = bif.alu_wb_taken;
            rob[i].target = bif.alu_wb_target;
          end else if (bif.lsb_wb_en && rob[i].id == int'(bif.lsb_wb_id) && !rob[i].rdy
                       && !(bif.alu_wb_en && bif.alu_wb_id == bif.lsb_wb_id)) begin
            rob[i].rdy = 1;
            rob[i].val = bif.lsb_wb_val;
          end
        end
      end
      md_mis = 0;
      if (md_commit) begin
        md_mis     = md_head.br && (md_head.taken != md_head.pred);
        md_exp.id  = md_head.id;
        md_exp.rd  = md_head.rd;
        md_exp.val = md_head.val;
        md_exp.st  = md_head.st;
        md_exp.fl  = md_mis;
        md_exp.fpc = md_head.taken ? md_head.target : md_head.pc + 32'd4;
        exp_q.push_back(md_exp);
        void'(rob.pop_front());
      end
      if (md_issue) begin
        md_new.id     = m_tail;
        md_new.rd     = bif.issue_rd;
        md_new.pc     = bif.issue_pc;
        md_new.val    = bif.issue_val;
        md_new.target = 0;
        md_new.st     = bif.issue_is_store;
        md_new.br     = bif.issue_is_br;
        md_new.pred   = bif.issue_pred_taken;
        md_new.taken  = 0;
        md_new.rdy    = bif.issue_done;
        rob.push_back(md_new);
        m_tail = (m_tail + 1) % DEPTH;
      end
      if (md_mis) begin
        rob.delete();
        m_tail = 0;
      end
      m_flush = md_mis;
    end
  end

  // Monitor: status every cycle, commit payload whenever the DUT retires.
  exp_t mon_e;
  initial forever begin
    @(negedge clk);
    check("full", bif.full, 32'(rob.size() == DEPTH));
    check("empty", bif.empty, 32'(rob.size() == 0));
    check("free_rob_id", bif.free_rob_id, 32'(m_tail));
    if (bif.commit_en) begin
      if (exp_q.size() == 0) begin
        check("unexpected_commit", bif.commit_en, 0);
      end else begin
        mon_e = exp_q.pop_front();
        check("commit_id", bif.commit_id, 32'(mon_e.id));
        check("commit_rd", bif.commit_rd, mon_e.rd);
        check("commit_val", bif.commit_val, mon_e.val);
        check("commit_is_store", bif.commit_is_store, mon_e.st);
        check("commit_flush", bif.flush, mon_e.fl);
        if (mon_e.fl) check("flush_pc", bif.flush_pc, mon_e.fpc);
      end
    end else begin
      check("stray_flush", bif.flush, 0);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic idle();
    bif.issue_en         = 0;
    bif.issue_rd         = '0;
    bif.issue_pc         = '0;
    bif.issue_is_store   = 0;
    bif.issue_is_br      = 0;
    bif.issue_pred_taken = 0;
    bif.issue_done       = 0;
    bif.issue_val        = '0;
    bif.alu_wb_en        = 0;
    bif.alu_wb_id        = '0;
    bif.alu_wb_val       = '0;
    bif.alu_wb_taken     = 0;
    bif.alu_wb_target    = '0;
    bif.lsb_wb_en        = 0;
    bif.lsb_wb_id        = '0;
    bif.lsb_wb_val       = '0;
  endtask

  task automatic step();
    @(posedge clk);
    #2;
    idle();
  endtask

  task automatic issue(input logic [31:0] pc, input logic [4:0] rd, input bit st,
                       input bit br, input bit pred, input bit done, input logic [31:0] val);
    bif.issue_en         = 1;
    bif.issue_pc         = pc;
    bif.issue_rd         = rd;
    bif.issue_is_store   = st;
    bif.issue_is_br      = br;
    bif.issue_pred_taken = pred;
    bif.issue_done       = done;
    bif.issue_val        = val;
  endtask

  task automatic alu_wb(input int id, input logic [31:0] val, input bit tk, input logic [31:0] tgt);
    bif.alu_wb_en     = 1;
    bif.alu_wb_id     = IDX_W'(id);
    bif.alu_wb_val    = val;
    bif.alu_wb_taken  = tk;
    bif.alu_wb_target = tgt;
  endtask

  task automatic lsb_wb(input int id, input logic [31:0] val);
    bif.lsb_wb_en  = 1;
    bif.lsb_wb_id  = IDX_W'(id);
    bif.lsb_wb_val = val;
  endtask

  task automatic do_reset(input string tag);
    rst = 1;
    #1;
    check({tag, "_commit_en"}, bif.commit_en, 0);
    check({tag, "_flush"}, bif.flush, 0);
    check({tag, "_flush_pc"}, bif.flush_pc, 0);
    check({tag, "_commit_id"}, bif.commit_id, 0);
    check({tag, "_commit_rd"}, bif.commit_rd, 0);
    check({tag, "_commit_val"}, bif.commit_val, 0);
    check({tag, "_commit_is_store"}, bif.commit_is_store, 0);
    check({tag, "_full"}, bif.full, 0);
    check({tag, "_empty"}, bif.empty, 1);
    check({tag, "_free_rob_id"}, bif.free_rob_id, 0);
    repeat (2) @(posedge clk);
    #2;
    rst = 0;
    idle();
  endtask

  // Write back the oldest pending entries with correct branch outcomes until empty.
  task automatic drain();
    bit found;
    for (int k = 0; k < 300 && rob.size() > 0; k++) begin
      found = 0;
      for (int i = 0; i < rob.size() && !found; i++) begin
        if (!rob[i].rdy) begin
          alu_wb(rob[i].id, $urandom, rob[i].pred, $urandom);
          found = 1;
        end
      end
      step();
    end
    repeat (3) step();
  endtask

  int br_id;
  int pick;
  bit isbr;

  initial begin
    idle();
    bif.rdy = 1;
    #1;
    do_reset("rst_init");

    // Three entries completing out of order retire in order.
    for (int i = 0; i < 3; i++) begin
      issue(32'h1000 + 32'(4 * i), 5'(i + 1), 0, 0, 0, 0, 0);
      step();
    end
    alu_wb(2, 32'hA2, 0, 0); step();
    alu_wb(0, 32'hA0, 0, 0); step();
    alu_wb(1, 32'hA1, 0, 0); step();
    repeat (4) step();
    check("empty_after_inorder", bif.empty, 1);

    // Fill to DEPTH, refused extra issue, refused issue while full and committing.
    do_reset("rst_fill");
    for (int i = 0; i < DEPTH; i++) begin
      issue(32'h2000 + 32'(4 * i), 5'(i), i[0], 0, 0, 0, 32'(i));
      step();
    end
    check("full_after_fill", bif.full, 1);
    check("tail_wrapped", bif.free_rob_id, 0);
    issue(32'h3000, 5'd9, 0, 0, 0, 1, 32'h99); step();
    check("full_refuses", bif.free_rob_id, 0);
    alu_wb(0, 32'hB0, 0, 0); step();
    issue(32'h3004, 5'd10, 0, 0, 0, 1, 32'h98); step();
    check("full_commit_refuses", bif.free_rob_id, 0);
    issue(32'h3008, 5'd11, 0, 0, 0, 1, 32'h97); step();
    check("issue_after_free", bif.free_rob_id, 1);
    drain();

    // Mispredicted not-taken branch redirects to target and drops younger work.
    br_id = m_tail;
    issue(32'h100, 5'd5, 0, 1, 0, 0, 0); step();
    issue(32'h104, 5'd6, 0, 0, 0, 1, 32'h66); step();
    issue(32'h108, 5'd7, 0, 0, 0, 1, 32'h77); step();
    alu_wb(br_id, 32'h11, 1, 32'h200); step();
    step();
    check("mis_t_commit_en", bif.commit_en, 1);
    check("mis_t_flush", bif.flush, 1);
    check("mis_t_flush_pc", bif.flush_pc, 32'h200);
    check("mis_t_empty", bif.empty, 1);
    issue(32'h10C, 5'd8, 0, 0, 0, 1, 32'h88); step();
    check("flush_blocks_issue", bif.free_rob_id, 0);
    check("flush_pulse_ends", bif.flush, 0);
    repeat (2) step();

    // Mispredicted taken branch falls through to pc+4; correct branch commits cleanly.
    br_id = m_tail;
    issue(32'h100, 5'd3, 0, 1, 1, 0, 0); step();
    alu_wb(br_id, 32'h22, 0, 32'h300); step();
    step();
    check("mis_nt_flush_pc", bif.flush_pc, 32'h104);
    step();
    br_id = m_tail;
    issue(32'h180, 5'd4, 0, 1, 1, 0, 0); step();
    alu_wb(br_id, 32'h33, 1, 32'h400); step();
    step();
    check("good_br_commit_en", bif.commit_en, 1);
    check("good_br_flush", bif.flush, 0);
    check("flush_pc_holds", bif.flush_pc, 32'h104);

    // ALU beats LSB on the same id; writeback to a retired id is dropped.
    do_reset("rst_wbpri");
    for (int i = 0; i < 4; i++) begin
      issue(32'h500 + 32'(4 * i), 5'(20 + i), 0, 0, 0, 0, 0);
      step();
    end
    alu_wb(0, 32'h50, 0, 0); step();
    alu_wb(1, 32'h51, 0, 0); step();
    alu_wb(2, 32'h52, 0, 0); step();
    alu_wb(3, 32'd5, 0, 0); lsb_wb(3, 32'd9); step();
    step();
    check("prio_commit_id", bif.commit_id, 3);
    check("prio_commit_val", bif.commit_val, 5);
    lsb_wb(3, 32'd77); alu_wb(3, 32'd88, 0, 0); step();
    repeat (3) step();
    check("freed_wb_empty", bif.empty, 1);
    check("freed_wb_no_commit", bif.commit_val, 5);

    // rdy low freezes a ready head; reset mid-stream clears everything at once.
    issue(32'h600, 5'd12, 1, 0, 0, 1, 32'h33); step();
    bif.rdy = 0;
    for (int i = 0; i < 3; i++) begin
      issue(32'h700, 5'd13, 0, 0, 0, 1, 32'h44);
      step();
      check("rdy_low_no_commit", bif.commit_en, 0);
    end
    bif.rdy = 1;
    step();
    check("rdy_high_commit", bif.commit_en, 1);
    check("rdy_high_val", bif.commit_val, 32'h33);
    for (int i = 0; i < 3; i++) begin
      issue(32'h800 + 32'(4 * i), 5'(i + 1), 0, 0, 0, i == 0, 32'h80);
      step();
    end
    do_reset("rst_mid");

    // Randomised traffic against the model.
    for (int n = 0; n < 600; n++) begin
      bif.rdy = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 2) != 0) begin
        isbr = ($urandom_range(0, 3) == 0);
        issue($urandom, 5'($urandom), isbr ? 1'b0 : 1'($urandom_range(0, 1)), isbr,
              1'($urandom_range(0, 1)), isbr ? 1'b0 : ($urandom_range(0, 3) == 0), $urandom);
      end
      if (rob.size() > 0 && $urandom_range(0, 9) < 6) begin
        pick = $urandom_range(0, rob.size() - 1);
        alu_wb(rob[pick].id, $urandom,
               ($urandom_range(0, 3) == 0) ? !rob[pick].pred : rob[pick].pred, $urandom);
      end else if ($urandom_range(0, 9) == 0) begin
        alu_wb($urandom_range(0, DEPTH - 1), $urandom, 1'($urandom_range(0, 1)), $urandom);
      end
      if (rob.size() > 0 && $urandom_range(0, 9) < 4) begin
        pick = $urandom_range(0, rob.size() - 1);
        lsb_wb(rob[pick].id, $urandom);
      end
      step();
    end
    bif.rdy = 1;
    drain();

    check("pending_commits", 32'(exp_q.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
